spike_classifier: RTL
=====================

Name: spike_classifier

Overview:
Downstream consumer of the 10-bit spike vector produced by the network top. Over a programmable window of timesteps, it counts output spikes per class, skipping a fixed warm-up. It then scans the counters for the argmax and reports the winning class, its count and a tie flag. It is the rate-decoding stage between the network and the host/IO logic.

Parameters:
NUM_CLASSES, 10, number of output neurons/classes (width of spikes)
CNT_W, 8, width of each per-class spike counter; counters saturate
STEP_W, 8, width of num_steps
WARMUP, 3, ce-qualified timesteps ignored after start; covers the 3-layer registered pipeline latency

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous and active-low
ce  in  1  timestep strobe; the same enable that advances the network
start  in  1  begin a classification window; sampled only in IDLE
num_steps  in  STEP_W  counted timesteps; latched on start
spikes  in  NUM_CLASSES  network output spike vector
busy  out  1  high in WARM, ACCUM and SCAN
done  out  1  one-cycle pulse when results become valid
class_idx  out  clog2(NUM_CLASSES)  winning class
class_count  out  CNT_W  spike count of the winning class
tie  out  1  another class equals the maximum

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters, step/warm counters, class_idx, class_count, tie, done and busy are 0.
- States: IDLE, WARM, ACCUM, SCAN, DONE.
- IDLE, start=1:
  - Clear all class counters.
  - Latch num_steps into step_cnt and load warm_cnt=WARMUP.
  - Next state is WARM, or ACCUM if WARMUP=0.
  - class_idx, class_count and tie keep their previous values until DONE.
- start outside IDLE is ignored (no restart, no error).
- WARM: each clk with ce=1 decrements warm_cnt; spikes are ignored. When a ce cycle sees warm_cnt==1, next state is ACCUM.
- ACCUM: each clk with ce=1:
  - counter[i] += spikes[i] for every i, saturating at 2^CNT_W-1.
  - step_cnt decrements.
  - When that ce cycle sees step_cnt==1, next state is SCAN.
  - Cycles with ce=0 change nothing.
- num_steps=0: ACCUM is skipped (WARM/IDLE goes directly to SCAN); all counts are 0.
- SCAN: one class per clk, k=0..NUM_CLASSES-1, independent of ce.
  - Running best initialises to k=0.
  - For k>0: if counter[k] > best_cnt, take k and clear tie. If counter[k] == best_cnt, set tie and keep the lower index.
  - SCAN lasts exactly NUM_CLASSES cycles, then goes to DONE.
- DONE: a single cycle.
  - done=1; class_idx, class_count and tie are registered and valid from this cycle.
  - They hold until the next DONE.
  - Next state is IDLE. busy=0 in DONE.
- Latency: with ce held high, done is asserted WARMUP + N + NUM_CLASSES + 1 clks after the start cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse.
- The spikes width must equal NUM_CLASSES. Counters never wrap.

Decomposition:
- Shared package nn_pkg: NUM_CLASSES, CLASS_W = clog2(NUM_CLASSES), and the classifier state enum (IDLE/WARM/ACCUM/SCAN/DONE). The network top takes neurons_2 from the same constant.
- One natural sub-module, sat_counter (parameter W; inputs clr, inc; saturating output), instantiated NUM_CLASSES times through a generate loop.
- The FSM, step/warm counters and the argmax scan stay in spike_classifier.

Test Plan:
1. WARMUP=3, num_steps=5, ce=1 constant, spikes=10'b0000001000 every cycle.
   -> spikes in the 3 warm-up cycles are not counted.
   -> done exactly 3+5+10+1=19 clks after start, with class_idx=3, class_count=5, tie=0.
2. num_steps=4, ce toggling 1/0, spikes=10'h3FF only on ce=0 cycles and 0 on ce=1 cycles.
   -> all counts 0; class_idx=0, count=0, tie=1.
3. Class 7 spikes 6 times, class 2 spikes 6 times, class 9 spikes 5 times.
   -> class_idx=2, class_count=6, tie=1.
4. CNT_W=4, num_steps=40, spikes[5]=1 always.
   -> class_count saturates at 15, class_idx=5, no wrap to 0.
5. num_steps=0, then start.
   -> no ACCUM; done after WARMUP+NUM_CLASSES+1 clks with class_idx=0, count=0, tie=1.
6. rst_n=0 during ACCUM; also start pulsed during SCAN.
   -> reset: outputs 0 immediately, state IDLE, no done pulse.
   -> start during SCAN: ignored; the scan completes with the original result.

Source files
------------

// File: rtl/nn_pkg.sv
// Constants and types shared by the network top and the rate-decoding classifier.
package nn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);

    typedef enum logic [2:0] {
        CLS_IDLE,
        CLS_WARM,
        CLS_ACCUM,
        CLS_SCAN,
        CLS_DONE
    } cls_state_t;

endpackage

// File: rtl/spike_classifier_if.sv
// Control and result bundle between the timestep source/host and the classifier.
interface spike_classifier_if #(
    parameter int N_CLS  = nn_pkg::NUM_CLASSES,
    parameter int CNT_W  = 8,
    parameter int STEP_W = 8
);
    logic                        ce;
    logic                        start;
    logic [STEP_W-1:0]           num_steps;
    logic [N_CLS-1:0]            spikes;
    logic                        busy;
    logic                        done;
    logic [$clog2(N_CLS)-1:0]    class_idx;
    logic [CNT_W-1:0]            class_count;
    logic                        tie;

    modport master (
        output ce, start, num_steps, spikes,
        input  busy, done, class_idx, class_count, tie
    );

    modport slave (
        input  ce, start, num_steps, spikes,
        output busy, done, class_idx, class_count, tie
    );
endinterface

// File: rtl/spike_classifier_sat_counter.sv
// Per-class spike counter: synchronous clear, increments stick at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; increments at full scale are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spike_classifier.sv
// Rate decoder: counts output spikes per class over a window of timesteps
// (after a warm-up covering the network pipeline), then scans for the argmax.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   CLS_IDLE  | waiting for start; results hold their last values
//   CLS_WARM  | discarding WARMUP ce-qualified timesteps
//   CLS_ACCUM | adding spikes into the per-class counters on each ce
//   CLS_SCAN  | one class per clock, tracking best count / index / tie
//   CLS_DONE  | single-cycle done pulse, results valid
module spike_classifier
    import nn_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int STEP_W = 8,
    parameter int WARMUP = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    spike_classifier_if.slave  bus
);

    localparam int WARM_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    cls_state_t          state;
    cls_state_t          state_nxt;

    logic [STEP_W-1:0]   step_cnt;
    logic [WARM_W-1:0]   warm_cnt;
    logic [CLASS_W-1:0]  scan_k;
    logic                scan_last;

    logic                clr_cnt;
    logic                inc_en;
    logic [CNT_W-1:0]    cnt [NUM_CLASSES];
    logic [CNT_W-1:0]    cnt_k;

    logic [CLASS_W-1:0]  best_idx;
    logic [CNT_W-1:0]    best_cnt;
    logic                best_tie;
    logic [CLASS_W-1:0]  nb_idx;
    logic [CNT_W-1:0]    nb_cnt;
    logic                nb_tie;

    logic [CLASS_W-1:0]  res_idx;
    logic [CNT_W-1:0]    res_cnt;
    logic                res_tie;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_cnt),
                .inc   (inc_en & bus.spikes[gi]),
                .cnt   (cnt[gi])
            );
        end
    endgenerate

    assign scan_last = (scan_k == CLASS_W'(NUM_CLASSES - 1));
    assign cnt_k     = cnt[scan_k];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero-length window goes straight to the scan.
    always_comb begin
        state_nxt = state;
        case (state)
            CLS_IDLE: begin
                if (bus.start) begin
                    if (WARMUP != 0)              state_nxt = CLS_WARM;
                    else if (bus.num_steps == '0) state_nxt = CLS_SCAN;
                    else                          state_nxt = CLS_ACCUM;
                end
            end
            CLS_WARM: begin
                if (bus.ce && (warm_cnt == WARM_W'(1))) begin
                    state_nxt = (step_cnt == '0) ? CLS_SCAN : CLS_ACCUM;
                end
            end
            CLS_ACCUM: begin
                if (bus.ce && (step_cnt == STEP_W'(1))) state_nxt = CLS_SCAN;
            end
            CLS_SCAN: begin
                if (scan_last) state_nxt = CLS_DONE;
            end
            CLS_DONE: state_nxt = CLS_IDLE;
            default:  state_nxt = CLS_IDLE;
        endcase
    end

    // State-decoded outputs and counter controls.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        clr_cnt  = 1'b0;
        inc_en   = 1'b0;
        case (state)
            CLS_IDLE:  clr_cnt  = bus.start;
            CLS_WARM:  bus.busy = 1'b1;
            CLS_ACCUM: begin
                bus.busy = 1'b1;
                inc_en   = bus.ce;
            end
            CLS_SCAN:  bus.busy = 1'b1;
            CLS_DONE:  bus.done = 1'b1;
            default:   bus.busy = 1'b0;
        endcase
    end

    // One argmax step: strictly greater takes over, equal keeps the lower index.
    always_comb begin
        nb_idx = best_idx;
        nb_cnt = best_cnt;
        nb_tie = best_tie;
        if (scan_k == '0) begin
            nb_idx = '0;
            nb_cnt = cnt_k;
            nb_tie = 1'b0;
        end else if (cnt_k > best_cnt) begin
            nb_idx = scan_k;
            nb_cnt = cnt_k;
            nb_tie = 1'b0;
        end else if (cnt_k == best_cnt) begin
            nb_tie = 1'b1;
        end
    end

    // Window/warm-up counters, scan registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            warm_cnt <= '0;
            scan_k   <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            best_tie <= 1'b0;
            res_idx  <= '0;
            res_cnt  <= '0;
            res_tie  <= 1'b0;
        end else begin
            case (state)
                CLS_IDLE: begin
                    if (bus.start) begin
                        step_cnt <= bus.num_steps;
                        warm_cnt <= WARM_W'(WARMUP);
                        scan_k   <= '0;
                    end
                end
                CLS_WARM: begin
                    if (bus.ce) warm_cnt <= warm_cnt - WARM_W'(1);
                end
                CLS_ACCUM: begin
                    if (bus.ce) step_cnt <= step_cnt - STEP_W'(1);
                end
                CLS_SCAN: begin
                    scan_k   <= scan_k + CLASS_W'(1);
                    best_idx <= nb_idx;
                    best_cnt <= nb_cnt;
                    best_tie <= nb_tie;
                    if (scan_last) begin
                        res_idx <= nb_idx;
                        res_cnt <= nb_cnt;
                        res_tie <= nb_tie;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.class_idx   = res_idx;
    assign bus.class_count = res_cnt;
    assign bus.tie         = res_tie;

endmodule
